// File: rtl/uart_display_sequencer.sv
// uart_display_sequencer
// Queues bytes from the UART receiver in a small circular FIFO and paces
// them onto the dual hex display: every byte is preceded by a blank gap of
// BLANK_CYCLES clocks and then held for HOLD_CYCLES clocks. After the queue
// drains, the last byte shown stays lit until a new one arrives.

module uart_display_sequencer #(
   parameter int DEPTH        = 4,
   parameter int HOLD_CYCLES  = 25_000_000,
   parameter int BLANK_CYCLES = 2_500_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               rx_byte,
   input  logic                     rx_data_valid,
   output logic [7:0]               disp_byte,
   output logic                     disp_on,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);

   // Pointer and count widths. DEPTH is a power of two, so the pointers
   // wrap modulo DEPTH simply by overflowing.
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // The one timer serves both the blank and hold phases, so it must
   // reach the larger of the two terminal values.
   localparam int TMAX = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [CW-1:0] ZERO_C     = {CW{1'b0}};
   localparam logic [CW-1:0] ONE_C      = CW'(1);
   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);
   localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
   localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
   localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r, wr_ptr_s;
   logic [AW-1:0] rd_ptr_r, rd_ptr_s;
   logic [CW-1:0] count_r, count_s;
   logic          push_s;
   logic          drop_s;

   // Sequencer state
   state_t        state_r, state_s;
   logic [TW-1:0] timer_r, timer_s;
   logic          pop_s;
   logic          shown_r, shown_s;

   // Registered outputs
   logic [7:0]    disp_byte_r, disp_byte_s;
   logic          disp_on_r, disp_on_s;
   logic          overflow_r, overflow_s;

   // Next-state logic for the IDLE/BLANK/SHOW sequencer and the pop strobe.
   always_comb begin
      state_s = state_r;
      timer_s = timer_r;
      pop_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (count_r != ZERO_C) begin
               state_s = ST_BLANK;
               timer_s = TIMER_ZERO;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_BLANK: begin
            // Entered only with a non-empty queue, and nothing else pops,
            // so the head is always valid when the gap expires.
            if (timer_r == BLANK_LAST) begin
               pop_s   = 1'b1;
               state_s = ST_SHOW;
               timer_s = TIMER_ZERO;
            end else begin
               timer_s = timer_r + TIMER_ONE;
            end
         end
         ST_SHOW: begin
            if (timer_r == HOLD_LAST) begin
               timer_s = TIMER_ZERO;
               if (count_r != ZERO_C) begin
                  state_s = ST_BLANK;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               timer_s = timer_r + TIMER_ONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            timer_s = TIMER_ZERO;
         end
      endcase
   end

   // Push/drop decision: a full queue still accepts a byte if it pops in the same cycle.
   always_comb begin
      push_s = 1'b0;
      drop_s = 1'b0;
      if (rx_data_valid) begin
         if ((count_r < DEPTH_C) || pop_s) begin
            push_s = 1'b1;
         end else begin
            drop_s = 1'b1;
         end
      end else begin
         push_s = 1'b0;
         drop_s = 1'b0;
      end
   end

   // FIFO pointer and occupancy updates; a push with a pop keeps the count.
   always_comb begin
      wr_ptr_s = wr_ptr_r;
      rd_ptr_s = rd_ptr_r;
      count_s  = count_r;
      if (push_s) begin
         wr_ptr_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_s = wr_ptr_r;
      end
      if (pop_s) begin
         rd_ptr_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + ONE_C;
         2'b01:   count_s = count_r - ONE_C;
         default: count_s = count_r;
      endcase
   end

   // Next values of the display byte, the lit flag and the sticky overflow.
   always_comb begin
      disp_byte_s = disp_byte_r;
      shown_s     = shown_r | pop_s;
      overflow_s  = overflow_r | drop_s;
      disp_on_s   = 1'b0;
      if (pop_s) begin
         disp_byte_s = mem_r[rd_ptr_r];
      end else begin
         disp_byte_s = disp_byte_r;
      end
      // Lit while showing, and while idle once something has been shown.
      case (state_s)
         ST_SHOW:  disp_on_s = 1'b1;
         ST_IDLE:  disp_on_s = shown_s;
         ST_BLANK: disp_on_s = 1'b0;
         default:  disp_on_s = 1'b0;
      endcase
   end

   // FIFO storage write. At full with a same-cycle pop the write may land on
   // the slot being read; the read above still sees the old contents.
   always_ff @(posedge clk) begin
      if (!rst && push_s) begin
         mem_r[wr_ptr_r] <= rx_byte;
      end
   end

   // State, pointer and output registers with synchronous reset priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         timer_r     <= TIMER_ZERO;
         wr_ptr_r    <= {AW{1'b0}};
         rd_ptr_r    <= {AW{1'b0}};
         count_r     <= ZERO_C;
         shown_r     <= 1'b0;
         disp_byte_r <= 8'h00;
         disp_on_r   <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         state_r     <= state_s;
         timer_r     <= timer_s;
         wr_ptr_r    <= wr_ptr_s;
         rd_ptr_r    <= rd_ptr_s;
         count_r     <= count_s;
         shown_r     <= shown_s;
         disp_byte_r <= disp_byte_s;
         disp_on_r   <= disp_on_s;
         overflow_r  <= overflow_s;
      end
   end

   assign disp_byte  = disp_byte_r;
   assign disp_on    = disp_on_r;
   assign fifo_count = count_r;
   assign overflow   = overflow_r;

endmodule

// File: tb/tb_uart_display_sequencer.sv
// tb_uart_display_sequencer
// Bench for uart_display_sequencer with DEPTH=4, HOLD_CYCLES=8, BLANK_CYCLES=2.
// Every clock is compared against a queue-based reference model; directed
// scenarios additionally check hand-derived constants at key cycles.

module tb_uart_display_sequencer;

   localparam int DEPTH = 4;
   localparam int HOLD  = 8;
   localparam int BLANK = 2;

   localparam int M_IDLE  = 0;
   localparam int M_BLANK = 1;
   localparam int M_SHOW  = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_data_valid = 1'b0;
   logic [7:0] disp_byte;
   logic       disp_on;
   logic [2:0] fifo_count;
   logic       overflow;

   uart_display_sequencer #(
      .DEPTH        (DEPTH),
      .HOLD_CYCLES  (HOLD),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_byte       (rx_byte),
      .rx_data_valid (rx_data_valid),
      .disp_byte     (disp_byte),
      .disp_on       (disp_on),
      .fifo_count    (fifo_count),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // Reference model: a queue of pending bytes plus a phase countdown.
   logic [7:0] m_q[$];
   int         m_mode  = M_IDLE;
   int         m_left  = 0;
   logic       m_shown = 1'b0;
   logic [7:0] m_disp  = 8'h00;
   logic       m_on    = 1'b0;
   logic       m_ovf   = 1'b0;

   task automatic model_step(input logic r, input logic v, input logic [7:0] b);
      int   cnt;
      logic pop;
      if (r) begin
         m_q.delete();
         m_mode  = M_IDLE;
         m_left  = 0;
         m_shown = 1'b0;
         m_disp  = 8'h00;
         m_on    = 1'b0;
         m_ovf   = 1'b0;
      end else begin
         cnt = m_q.size();
         pop = 1'b0;
         if (m_mode == M_IDLE) begin
            if (cnt > 0) begin
               m_mode = M_BLANK;
               m_left = BLANK;
            end
         end else if (m_mode == M_BLANK) begin
            if (m_left == 1) begin
               pop     = 1'b1;
               m_disp  = m_q.pop_front();
               m_shown = 1'b1;
               m_mode  = M_SHOW;
               m_left  = HOLD;
            end else begin
               m_left--;
            end
         end else begin
            if (m_left == 1) begin
               if (cnt > 0) begin
                  m_mode = M_BLANK;
                  m_left = BLANK;
               end else begin
                  m_mode = M_IDLE;
               end
            end else begin
               m_left--;
            end
         end
         if (v) begin
            if (cnt < DEPTH || pop) m_q.push_back(b);
            else m_ovf = 1'b1;
         end
         m_on = (m_mode == M_SHOW) || (m_mode == M_IDLE && m_shown);
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, compare #1 later.
   task automatic tick(input logic r, input logic v, input logic [7:0] b);
      logic [2:0] m_cnt;
      rst = r;
      rx_data_valid = v;
      rx_byte = b;
      @(posedge clk);
      model_step(r, v, b);
      #1;
      cyc++;
      m_cnt = 3'(m_q.size());
      vectors++;
      if (disp_byte !== m_disp || disp_on !== m_on || fifo_count !== m_cnt || overflow !== m_ovf) begin
         miscompares++;
         $display("FAIL model cyc=%0d got byte=%h on=%b cnt=%0d ovf=%b exp byte=%h on=%b cnt=%0d ovf=%b",
                  cyc, disp_byte, disp_on, fifo_count, overflow, m_disp, m_on, m_cnt, m_ovf);
      end
   endtask

   task automatic expect8(input string name, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   task automatic expect_all(input string name, input logic [7:0] eb, input logic eon,
                             input logic [2:0] ecnt, input logic eovf);
      expect8({name, "_byte"}, disp_byte, eb);
      expect8({name, "_on"},   {7'd0, disp_on}, {7'd0, eon});
      expect8({name, "_cnt"},  {5'd0, fifo_count}, {5'd0, ecnt});
      expect8({name, "_ovf"},  {7'd0, overflow}, {7'd0, eovf});
   endtask

   task automatic do_reset();
      tick(1'b1, 1'b0, 8'h00);
      tick(1'b1, 1'b0, 8'h00);
      tick(1'b0, 1'b0, 8'h00);
      cyc = 0;
   endtask

   typedef struct {
      logic       r;
      logic       v;
      logic [7:0] b;
      logic [7:0] eb;
      logic       eon;
      logic [2:0] ecnt;
      logic       eovf;
   } vec_t;

   vec_t       tbl[6];
   logic [7:0] seen[$];
   logic [7:0] prev;

   initial begin
      // Single-byte vectors: row 0 is a reset, rows 1.. start at cycle 0.
      tbl[0] = '{r:1'b1, v:1'b0, b:8'h00, eb:8'h00, eon:1'b0, ecnt:3'd0, eovf:1'b0};
      tbl[1] = '{r:1'b0, v:1'b1, b:8'hA5, eb:8'h00, eon:1'b0, ecnt:3'd1, eovf:1'b0};
      tbl[2] = '{r:1'b0, v:1'b0, b:8'h00, eb:8'h00, eon:1'b0, ecnt:3'd1, eovf:1'b0};
      tbl[3] = '{r:1'b0, v:1'b0, b:8'h00, eb:8'h00, eon:1'b0, ecnt:3'd1, eovf:1'b0};
      tbl[4] = '{r:1'b0, v:1'b0, b:8'h00, eb:8'hA5, eon:1'b1, ecnt:3'd0, eovf:1'b0};
      tbl[5] = '{r:1'b0, v:1'b0, b:8'h00, eb:8'hA5, eon:1'b1, ecnt:3'd0, eovf:1'b0};

      // Reset from a random busy state, with a strobe during reset.
      tick(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 15; i++) tick(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      tick(1'b1, 1'b1, 8'hFF);
      tick(1'b1, 1'b0, 8'h00);
      expect_all("reset", 8'h00, 1'b0, 3'd0, 1'b0);

      // Single byte, table-driven, then held for 100 cycles.
      for (int i = 0; i < 6; i++) begin
         tick(tbl[i].r, tbl[i].v, tbl[i].b);
         expect_all($sformatf("single%0d", i), tbl[i].eb, tbl[i].eon, tbl[i].ecnt, tbl[i].eovf);
      end
      for (int i = 0; i < 100; i++) begin
         tick(1'b0, 1'b0, 8'h00);
         if (i % 25 == 0) expect_all("single_hold", 8'hA5, 1'b1, 3'd0, 1'b0);
      end

      // Burst of three bytes.
      do_reset();
      tick(1'b0, 1'b1, 8'h12);
      tick(1'b0, 1'b1, 8'h34);
      tick(1'b0, 1'b1, 8'h56);
      for (int i = 0; i < 37; i++) begin
         tick(1'b0, 1'b0, 8'h00);
         if (cyc <= 11) begin
            expect8("burst_b", disp_byte, 8'h12);
            expect8("burst_on", {7'd0, disp_on}, 8'h01);
         end else if (cyc <= 13) begin
            expect8("burst_on", {7'd0, disp_on}, 8'h00);
         end else if (cyc <= 21) begin
            expect8("burst_b", disp_byte, 8'h34);
            expect8("burst_on", {7'd0, disp_on}, 8'h01);
         end else if (cyc <= 23) begin
            expect8("burst_on", {7'd0, disp_on}, 8'h00);
         end else begin
            expect8("burst_b", disp_byte, 8'h56);
            expect8("burst_on", {7'd0, disp_on}, 8'h01);
         end
         expect8("burst_ovf", {7'd0, overflow}, 8'h00);
      end

      // Overflow: six strobes back to back, the sixth is dropped.
      do_reset();
      seen.delete();
      prev = disp_byte;
      for (int i = 0; i < 70; i++) begin
         if (i < 6) tick(1'b0, 1'b1, 8'(i + 1));
         else tick(1'b0, 1'b0, 8'h00);
         if (cyc == 4) expect8("ovf_cnt4", {5'd0, fifo_count}, 8'd3);
         if (cyc == 5) begin
            expect8("ovf_cnt5", {5'd0, fifo_count}, 8'd4);
            expect8("ovf_early", {7'd0, overflow}, 8'h00);
         end
         if (cyc >= 6) expect8("ovf_sticky", {7'd0, overflow}, 8'h01);
         if (disp_byte !== prev) seen.push_back(disp_byte);
         prev = disp_byte;
      end
      expect8("ovf_nseen", 8'(seen.size()), 8'd5);
      for (int k = 0; k < seen.size() && k < 5; k++) expect8("ovf_seq", seen[k], 8'(k + 1));

      // Strobe into a full FIFO in its pop cycle.
      do_reset();
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 8'hB0 + 8'(i));
      expect8("full_cnt", {5'd0, fifo_count}, 8'd4);
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 8'h00);
      tick(1'b0, 1'b1, 8'hB5);
      expect_all("full_pop", 8'hB1, 1'b1, 3'd4, 1'b0);
      for (int i = 0; i < 66; i++) tick(1'b0, 1'b0, 8'h00);
      expect_all("full_last", 8'hB5, 1'b1, 3'd0, 1'b0);

      // Reset while the first of three queued bytes is showing.
      do_reset();
      tick(1'b0, 1'b1, 8'hC1);
      tick(1'b0, 1'b1, 8'hC2);
      tick(1'b0, 1'b1, 8'hC3);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'h00);
      expect_all("mid_show", 8'hC1, 1'b1, 3'd2, 1'b0);
      tick(1'b1, 1'b0, 8'h00);
      expect_all("mid_rst", 8'h00, 1'b0, 3'd0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         tick(1'b0, 1'b0, 8'h00);
         if (i % 10 == 9) expect_all("mid_after", 8'h00, 1'b0, 3'd0, 1'b0);
      end

      // Randomized traffic with occasional resets, checked by the model.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         tick(1'($urandom_range(0, 399) == 0),
              (i < 2000) ? 1'($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1)),
              8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_display_sequencer.md
# uart_display_sequencer

Sequences bytes from the UART receiver onto the dual 7-segment display. It buffers each `rx_byte`/`rx_data_valid` strobe in a small FIFO, then presents each byte for a fixed hold time, with a blanking gap between consecutive bytes. A burst of characters therefore stays readable instead of only the last one showing. It sits between the UART receiver and the two hex-digit decoders: `disp_byte[7:4]` drives the upper digit, `disp_byte[3:0]` the lower digit, and `disp_on` gates the segment outputs.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `HOLD_CYCLES`, 25_000_000: clocks each byte is shown before the next may replace it; ≥1.
- `BLANK_CYCLES`, 2_500_000: clocks of blank display before each new byte; ≥1.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `rx_byte`  in  8  received byte; sampled only when `rx_data_valid`=1.
- `rx_data_valid`  in  1  one-cycle strobe from the UART receiver.
- `disp_byte`  out  8  byte currently presented to the digit decoders.
- `disp_on`  out  1  1 = digits lit, 0 = all segments off.
- `fifo_count`  out  $clog2(DEPTH)+1  entries currently queued.
- `overflow`  out  1  sticky; set when a strobe is dropped.

## Operation
- **FIFO**
  - Circular buffer with read/write pointers that wrap modulo DEPTH, plus an explicit count.
  - Push when `rx_data_valid`=1 and either (count<DEPTH) or a pop occurs the same cycle.
  - Simultaneous push and pop leaves count unchanged. This is legal at full and at count=1.
  - A strobe while full with no pop is dropped, and `overflow` is set to 1. It stays 1 until `rst`.
- **FSM** (states IDLE, BLANK, SHOW), with one timer of width sufficient for max(HOLD_CYCLES, BLANK_CYCLES).
  - IDLE: if count>0, go to BLANK and clear the timer. Otherwise stay.
  - BLANK: timer increments each cycle. When timer==BLANK_CYCLES-1:
    - pop the FIFO head into `disp_byte`;
    - go to SHOW and clear the timer.
    - Count is always >0 here, since BLANK is only entered with count>0 and only the FSM pops.
  - SHOW: timer increments. When timer==HOLD_CYCLES-1: if count>0, go to BLANK (timer cleared); else go to IDLE.
- **`disp_on`**
  - 1 in SHOW, and in IDLE once at least one byte has been shown since reset.
  - 0 in BLANK, and in IDLE before the first byte.
  - The last byte stays displayed indefinitely while the queue is empty.
- `disp_byte` changes only on a pop. It holds its value through BLANK and IDLE.
- All outputs are registered.

## Timing
- **Reset values** (all synchronous, visible the cycle after `rst`=1 is sampled): `disp_byte`=0x00, `disp_on`=0, `fifo_count`=0, `overflow`=0, state IDLE, timer 0, pointers 0, shown flag 0.
- `rst` has priority over every other event, including a same-cycle push or pop.
- **Reset mid-operation:** queued bytes are discarded and any SHOW or BLANK is aborted.
- **Push latency:** a strobe sampled at cycle n makes `fifo_count` update at n+1.
- **Empty-IDLE latency:** with the FSM in IDLE and an empty queue, a strobe at cycle n gives:
  - BLANK from n+2, with `disp_on`=0 during cycles n+2 .. n+1+BLANK_CYCLES;
  - the pop at cycle n+1+BLANK_CYCLES;
  - `disp_byte` = new value and `disp_on`=1 from n+2+BLANK_CYCLES.
- **Per-byte period** with a queue backlog: exactly HOLD_CYCLES+BLANK_CYCLES.
- **`overflow`:** rises the cycle after the dropped strobe.

## Test plan
All scenarios use DEPTH=4, HOLD_CYCLES=8, BLANK_CYCLES=2.

- **Reset:** assert `rst` 2 cycles from random state → `disp_byte`=0x00, `disp_on`=0, `fifo_count`=0, `overflow`=0.
- **Single byte:** push 0xA5 at cycle 0 →
  - `fifo_count`=1 at cycle 1;
  - `disp_on`=0 at cycles 2–3;
  - `disp_byte`=0xA5 and `disp_on`=1 from cycle 4, held for ≥100 cycles;
  - `fifo_count`=0 from cycle 4.
- **Burst:** push 0x12, 0x34, 0x56 at cycles 0–2 →
  - 0x12 shown at cycles 4–11;
  - blank at 12–13; 0x34 shown at 14–21;
  - blank at 22–23; 0x56 from 24 onward;
  - `overflow`=0 throughout.
- **Overflow:** push 0x01–0x06 at cycles 0–5 →
  - pop at cycle 3 coincides with a push;
  - `fifo_count`=4 at cycle 5, and 0x06 is dropped;
  - `overflow`=1 from cycle 6;
  - displayed sequence is 0x01–0x05 only.
- **Push at full with pop:** fill the FIFO to 4 and strobe in the pop cycle → byte accepted, `fifo_count` stays 4, `overflow` stays 0.
- **Reset mid-SHOW:** queue 3 bytes and assert `rst` at cycle 7 → reset values at cycle 8; no further `disp_byte` change without new strobes.
